// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the single-port unified memory of the multicycle MIPS core.
// Serialises loader, fetch and data accesses through IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_memwrite,
    output logic          mem_irwrite,
    input  logic [DW-1:0] mem_data,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_LD   = 2'd1;
    localparam logic [1:0] G_IF   = 2'd2;
    localparam logic [1:0] G_DM   = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [1:0]    grant_q,    grant_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          we_q,       we_d;
    logic          last_dm_q,  last_dm_d;
    logic          ld_ack_q,   ld_ack_d;
    logic          if_ack_q,   if_ack_d;
    logic          dm_ack_q,   dm_ack_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    // A requester whose ack is high this cycle has not yet dropped req.
    logic ld_elig, if_elig, dm_elig;
    assign ld_elig = ld_req & ~ld_ack_q;
    assign if_elig = if_req & ~if_ack_q;
    assign dm_elig = dm_req & ~dm_ack_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        last_dm_d  = last_dm_q;
        ld_ack_d   = 1'b0;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                // last_dm_q=0 (reset, or after a data grant) hands the next tie to fetch.
                if (ld_elig) begin
                    state_d = S_ACCESS;
                    grant_d = G_LD;
                    addr_d  = ld_addr;
                    wdata_d = ld_wdata;
                    we_d    = 1'b1;
                end else if (if_elig && (!dm_elig || !last_dm_q)) begin
                    state_d   = S_ACCESS;
                    grant_d   = G_IF;
                    addr_d    = if_addr;
                    we_d      = 1'b0;
                    last_dm_d = 1'b1;
                end else if (dm_elig) begin
                    state_d   = S_ACCESS;
                    grant_d   = G_DM;
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    we_d      = dm_we;
                    last_dm_d = 1'b0;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP: begin
                state_d  = S_IDLE;
                grant_d  = G_NONE;
                ld_ack_d = (grant_q == G_LD);
                if_ack_d = (grant_q == G_IF);
                dm_ack_d = (grant_q == G_DM);
                if (grant_q == G_DM && !we_q) begin
                    dm_rdata_d = mem_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= G_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            last_dm_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            last_dm_q  <= last_dm_d;
            ld_ack_q   <= ld_ack_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign mem_a        = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_memwrite = (state_q == S_ACCESS) && we_q;
    assign mem_irwrite  = (state_q == S_ACCESS) && (grant_q == G_IF);
    assign grant        = grant_q;
    assign busy         = (state_q != S_IDLE);
    assign ld_ack       = ld_ack_q;
    assign if_ack       = if_ack_q;
    assign dm_ack       = dm_ack_q;
    assign dm_rdata     = dm_rdata_q;

endmodule
